p_mem_arbiter: RTL and testbench

Arbitrates a single physical-memory port between the pipelined I-cache and D-cache line-fill/write-back interfaces. The block sits between the two cache controllers and the cacheline adaptor. It grants one requester at a time and latches that requester's address and write data for the whole transaction. It routes the memory response back only to the granted cache, and alternates priority when both caches are waiting.

---
 rtl/cache_mux_types.sv | 13 +
 rtl/p_mem_arbiter.sv | 97 +++++++++
 tb/tb_p_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mux_types.sv
// Shared types for the I/D cache to physical-memory mux.
package cache_mux_types;

    // Arbiter FSM: a grant is held in *_BUSY until mem_resp, then one DONE
    // cycle lets the served cache drop its request before IDLE re-arbitrates.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/p_mem_arbiter.sv
// Physical-memory arbiter between I-cache and D-cache line traffic.
// One requester owns the adaptor port per transaction; its address and
// write line are latched at grant so the caches may change inputs freely.
module p_mem_arbiter
    import cache_mux_types::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    arb_state_t state;
    logic       last_d;     // 1 when the most recent completed grant went to D
    logic       i_req;
    logic       d_req;
    logic       grant_i;
    logic       grant_d;

    // Pick a winner in IDLE (ties go to whoever was not served last) and
    // route the adaptor response only to the cache that owns the port.
    always_comb begin
        i_req   = i_pmem_read;
        d_req   = d_pmem_read | d_pmem_write;
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE) begin
            grant_i = i_req & (~d_req | last_d);
            grant_d = d_req & ~grant_i;
        end
        i_pmem_resp  = mem_resp & (state == I_BUSY);
        d_pmem_resp  = mem_resp & (state == D_BUSY);
        i_pmem_rdata = mem_rdata;
        d_pmem_rdata = mem_rdata;
    end

    // FSM plus the registered adaptor request; reset aborts any transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            last_d      <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        state       <= I_BUSY;
                        mem_read    <= 1'b1;
                        mem_write   <= 1'b0;
                        mem_address <= i_pmem_address;
                    end else if (grant_d) begin
                        // Write wins if the D-cache raises both strobes.
                        state       <= D_BUSY;
                        mem_read    <= ~d_pmem_write;
                        mem_write   <= d_pmem_write;
                        mem_address <= d_pmem_address;
                        mem_wdata   <= d_pmem_wdata;
                    end
                end
                I_BUSY, D_BUSY: begin
                    if (mem_resp) begin
                        state     <= DONE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        last_d    <= (state == D_BUSY);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_p_mem_arbiter.sv
// Self-checking bench for p_mem_arbiter: table of lone transactions plus
// hand sequences for ties, fairness, input churn and reset abort.
module tb_p_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              i_pmem_read = 1'b0;
    logic [ADDR_W-1:0] i_pmem_address = '0;
    logic [LINE_W-1:0] i_pmem_rdata;
    logic              i_pmem_resp;
    logic              d_pmem_read = 1'b0;
    logic              d_pmem_write = 1'b0;
    logic [ADDR_W-1:0] d_pmem_address = '0;
    logic [LINE_W-1:0] d_pmem_wdata = '0;
    logic [LINE_W-1:0] d_pmem_rdata;
    logic              d_pmem_resp;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata = '0;
    logic              mem_resp = 1'b0;

    p_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit              is_i;
        bit              wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } exp_t;

    typedef struct {
        logic              i_rd, d_rd, d_wr;
        logic [ADDR_W-1:0] i_addr, d_addr;
        logic [LINE_W-1:0] wdata;
        int                lat;
        logic [LINE_W-1:0] rd;
        bit                exp_i, exp_wr;
        logic [ADDR_W-1:0] exp_addr;
    } vec_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit is_i, input bit wr, input logic [ADDR_W-1:0] a,
                        input logic [LINE_W-1:0] wd);
        exp_t e;
        e.is_i = is_i; e.wr = wr; e.addr = a; e.wdata = wd;
        q.push_back(e);
    endtask

    // Wait for the next grant, compare it with the scoreboard head, hold it
    // for lat cycles, pulse mem_resp, then check DONE and IDLE gap cycles.
    task automatic serve(input int lat, input logic [LINE_W-1:0] rd,
                         input bit drop, input bit mutate, output int waited);
        exp_t e;
        int   w = 0;
        while (!(mem_read || mem_write) && w < 20) begin
            tick();
            w++;
        end
        waited = w;
        if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty: got grant expected none");
            return;
        end
        e = q.pop_front();
        chk("grant_read",  mem_read,    !e.wr);
        chk("grant_write", mem_write,   e.wr);
        chk("grant_addr",  mem_address, e.addr);
        if (e.wr) chk("grant_wdata", mem_wdata, e.wdata);
        for (int k = 0; k < lat; k++) begin
            if (mutate) begin
                d_pmem_address = $urandom;
                d_pmem_wdata   = {8{$urandom}};
                i_pmem_address = $urandom;
            end
            tick();
            chk("hold_addr", mem_address, e.addr);
            chk("hold_req",  {mem_read, mem_write}, {!e.wr, e.wr});
            chk("early_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
        end
        mem_rdata = rd;
        mem_resp  = 1'b1;
        #1;
        chk("i_resp", i_pmem_resp, e.is_i);
        chk("d_resp", d_pmem_resp, !e.is_i);
        chk("rdata", e.is_i ? i_pmem_rdata : d_pmem_rdata, rd);
        tick();
        mem_resp = 1'b0;
        chk("done_idle_req", {mem_read, mem_write}, 2'b00);
        if (drop) begin
            if (e.is_i) i_pmem_read = 1'b0;
            else begin d_pmem_read = 1'b0; d_pmem_write = 1'b0; end
        end
        tick();
        chk("gap_req", {mem_read, mem_write}, 2'b00);
    endtask

    task automatic clear_reqs();
        i_pmem_read = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v[4];
        int   w;
        logic [LINE_W-1:0] a5;
        logic [LINE_W-1:0] c3;
        a5 = {8{32'hA5A5_A5A5}};
        c3 = {8{32'h3C3C_C3C3}};

        v[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_1040, 32'h0, '0, 5,
                 {8{32'h1111_2222}}, 1'b1, 1'b0, 32'h0000_1040};
        v[1] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_2080, c3, 3,
                 {8{32'h3333_4444}}, 1'b0, 1'b0, 32'h0000_2080};
        v[2] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_30C0, c3, 2,
                 {8{32'h5555_6666}}, 1'b0, 1'b1, 32'h0000_30C0};
        v[3] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_4100, a5, 1,
                 {8{32'h7777_8888}}, 1'b0, 1'b1, 32'h0000_4100};

        // Reset state and idle behaviour
        #12;
        chk("rst_req",   {mem_read, mem_write}, 2'b00);
        chk("rst_addr",  mem_address, '0);
        chk("rst_wdata", mem_wdata, '0);
        chk("rst_resp",  {i_pmem_resp, d_pmem_resp}, 2'b00);
        @(negedge clk);
        rst = 1'b1;
        tick();
        mem_resp = 1'b1; mem_rdata = a5;
        #1;
        chk("idle_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
        tick();
        mem_resp = 1'b0;
        chk("idle_no_req", {mem_read, mem_write}, 2'b00);

        // Lone requests from the table
        for (int i = 0; i < 4; i++) begin
            i_pmem_read = v[i].i_rd; d_pmem_read = v[i].d_rd; d_pmem_write = v[i].d_wr;
            i_pmem_address = v[i].i_addr; d_pmem_address = v[i].d_addr;
            d_pmem_wdata = v[i].wdata;
            push(v[i].exp_i, v[i].exp_wr, v[i].exp_addr, v[i].wdata);
            serve(v[i].lat, v[i].rd, 1'b1, 1'b0, w);
            chk("first_latency", w, 1);
            clear_reqs();
        end

        // Tie after reset: D first, then I; stale I in DONE not re-granted
        do_reset();
        i_pmem_read = 1'b1; i_pmem_address = 32'h100;
        d_pmem_write = 1'b1; d_pmem_address = 32'h200; d_pmem_wdata = a5;
        push(1'b0, 1'b1, 32'h200, a5);
        push(1'b1, 1'b0, 32'h100, '0);
        serve(2, c3, 1'b1, 1'b0, w);
        chk("tie_d_latency", w, 1);
        serve(2, a5, 1'b1, 1'b0, w);
        chk("tie_i_gap", w, 1);
        tick();
        chk("no_regrant", {mem_read, mem_write}, 2'b00);

        // D changes its inputs while busy
        d_pmem_read = 1'b1; d_pmem_address = 32'h0000_5140; d_pmem_wdata = c3;
        push(1'b0, 1'b0, 32'h0000_5140, c3);
        serve(4, a5, 1'b1, 1'b1, w);
        chk("mutate_latency", w, 1);
        clear_reqs();

        // Continuous requests alternate D,I,D,I,D,I
        do_reset();
        i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0a00;
        d_pmem_read = 1'b1; d_pmem_address = 32'h0000_0b00;
        for (int k = 0; k < 3; k++) begin
            push(1'b0, 1'b0, 32'h0000_0b00, '0);
            push(1'b1, 1'b0, 32'h0000_0a00, '0);
        end
        for (int k = 0; k < 6; k++) begin
            serve(1 + k % 3, {8{k[31:0]}}, 1'b0, 1'b0, w);
            chk("alt_gap", w, 1);
        end
        clear_reqs();
        tick();
        chk("alt_stop", {mem_read, mem_write}, 2'b00);

        // Reset asserted during D_BUSY aborts; request re-granted afterwards
        d_pmem_write = 1'b1; d_pmem_address = 32'h0000_6180; d_pmem_wdata = a5;
        tick();
        chk("pre_abort_write", mem_write, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("abort_req",   {mem_read, mem_write}, 2'b00);
        chk("abort_addr",  mem_address, '0);
        chk("abort_wdata", mem_wdata, '0);
        mem_resp = 1'b1;
        #1;
        chk("abort_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
        tick();
        mem_resp = 1'b0;
        rst = 1'b1;
        push(1'b0, 1'b1, 32'h0000_6180, a5);
        serve(2, c3, 1'b1, 1'b0, w);
        chk("regrant_latency", w, 1);
        clear_reqs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
